maze_carver_gen: RTL and testbench
==================================

# maze_carver_gen

Parametrised recursive-backtracker maze generator for a W×H cell grid. It replaces the fixed 16×16 carver in the maze subsystem. The block has an explicit coordinate stack, an internal LFSR, a start/done handshake, a programmable seed and start cell, and a registered cell read port that the renderer and the solver use.

## Interface
- `MAZE_W`, default 16: grid width in cells, range 1–64.
- `MAZE_H`, default 16: grid height in cells, range 1–64.
- `XW`, default `$clog2(MAZE_W)` (min 1): x coordinate width.
- `YW`, default `$clog2(MAZE_H)` (min 1): y coordinate width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request generation. Sampled only in IDLE or DONE.
- `seed` in 16: LFSR seed, captured with `start`.
- `start_x` in XW: first carved cell x, captured with `start`.
- `start_y` in YW: first carved cell y, captured with `start`.
- `busy` out 1: high from the cycle after `start` is accepted until generation completes.
- `done` out 1: high from completion until the next accepted `start` or reset.
- `cells_carved` out `$clog2(W*H+1)`: number of cells visited so far.
- `rd_x` in XW: read port x.
- `rd_y` in YW: read port y.
- `rd_cell` out 3: `{visited, wall_down, wall_right}` of (`rd_x`,`rd_y`), registered.

## Operation
- Cell store: W×H entries of 3 bits in flops. Reset and INIT value is `3'b011`: unvisited, both walls present.
- Stack: W·H entries of `{x,y}`. Pointer width is `$clog2(W*H+1)`. Overflow is impossible because each cell is pushed at most once.
- Start coordinates: an out-of-range `start_x` or `start_y` is replaced by 0. A `seed` of 0 is replaced by `16'hACE1`.
- Directions: 0 = up (y−1), 1 = left (x−1), 2 = down (y+1), 3 = right (x+1).
- FSM states:
  - IDLE → INIT on `start`.
  - INIT: clears one cell per cycle in raster order. After W·H cycles → SEED.
  - SEED: marks the start cell visited, pushes it, sets `cur` to the start cell and `cells_carved` to 1. → STEP.
  - STEP: computes the in-bounds, unvisited neighbour mask of `cur` combinationally.
    - Mask non-zero, carve: let r = `lfsr[1:0]`. Choose the first set direction in the order r, r+1, r+2, r+3 (mod 4). Remove the wall between `cur` and the chosen neighbour:
      - up clears `wall_down` of (x, y−1);
      - left clears `wall_right` of (x−1, y);
      - down clears `wall_down` of `cur`;
      - right clears `wall_right` of `cur`.
      
      Then mark the neighbour visited, push it, move `cur` to it, and increment `cells_carved`.
    - Mask zero, pop: decrement the pointer. If the pointer becomes 0 → DONE. Otherwise `cur` takes the new top entry.
  - DONE: holds the maze. `start` → INIT.
- `start` in INIT, SEED or STEP is ignored.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11. It advances once per clock in STEP only.
- Boundary walls are never cleared: `wall_right` of x=W−1 and `wall_down` of y=H−1 stay 1.
- A completed maze is a spanning tree: exactly W·H−1 walls are cleared and every cell is visited.

## Timing
- Reset values: `busy`=0, `done`=0, `cells_carved`=0, `rd_cell`=`3'b011`, state IDLE, stack pointer 0, LFSR `16'hACE1`.
- Start is accepted on edge E0. `busy` is high after E0 and `done` is cleared after E0.
- Phase lengths: INIT takes W·H edges, SEED takes 1, STEP takes exactly 2·W·H−1 (W·H−1 carves plus W·H pops).
- `done` rises and `busy` falls after edge E0+3·W·H. For 1×1 that is 3 edges; for 16×16 it is 768.
- Read port: `rd_cell` reflects the store state before edge N, for the address presented before edge N. Latency is 1 cycle. The port is valid in every state and shows in-progress contents during generation.
- Reset asserted mid-operation: all outputs and the store return to reset values immediately. The state is IDLE on deassertion.
- Carve write and read of the same cell on the same edge: the read returns the pre-write value.

## Structure
- `maze_pkg` holds:
  - the direction enum;
  - the cell bit indices (VISITED=2, WALL_DOWN=1, WALL_RIGHT=0);
  - the state enum;
  - `DEFAULT_SEED = 16'hACE1`.
- Sub-module `maze_lfsr`: 16-bit LFSR with `load`, `seed`, `adv` inputs. It zero-substitutes the seed. It supersedes `rand_num`.

## Test plan
- 1×1, `start` with seed 1 → `done` after 3 edges; `cells_carved`=1; `rd_cell(0,0)`=`3'b111`.
- 2×2, seed `16'h1234`, start (0,0) → `done` after 12 edges; exactly 3 internal walls cleared; all cells visited. A repeat run with the same seed gives an identical maze.
- 16×16, seeds 1, 2 and `16'hBEEF`:
  - `done` at 768 edges;
  - 255 walls cleared;
  - bench BFS reaches all 256 cells;
  - boundary walls all 1;
  - mazes from different seeds differ.
- Start (15,15) on 16×16 and start x=20 on 16×16 (substituted to 0) → in both runs the first carved cell reads visited right after SEED.
- Reset pulsed at cycle 100 of a 16×16 run:
  - `busy`=0, `done`=0, `cells_carved`=0 immediately;
  - every `rd_cell` = `3'b011`;
  - a fresh `start` completes at 768 edges.
- `start` held high throughout a run → ignored while `busy`; a new run begins from DONE; `seed`=0 produces the same maze as `seed`=`16'hACE1`.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze carver.
package maze_pkg;

  // Carve directions; numeric order is the order in which candidates are scanned.
  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirLeft  = 2'd1,
    DirDown  = 2'd2,
    DirRight = 2'd3
  } dir_e;

  // Bit positions inside a 3-bit cell: {visited, wall_down, wall_right}.
  localparam int unsigned VISITED    = 2;
  localparam int unsigned WALL_DOWN  = 1;
  localparam int unsigned WALL_RIGHT = 0;

  // Unvisited cell with both owned walls standing.
  localparam logic [2:0] CELL_INIT = 3'b011;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StSeed,
    StStep,
    StDone
  } state_e;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/maze_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with seed load; exposes the two low bits.
module maze_lfsr
  import maze_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [1:0]  rnd
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        fb;

  // Next-state: load has priority over advance; an all-zero seed would lock up.
  always_comb begin
    fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == 16'h0000) ? DEFAULT_SEED : seed;
    end else if (adv) begin
      lfsr_d = {fb, lfsr_q[15:1]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= DEFAULT_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign rnd = lfsr_q[1:0];

endmodule

// File: rtl/maze_carver_gen.sv
// Recursive-backtracker maze generator with explicit stack and registered cell read port.
module maze_carver_gen
  import maze_pkg::*;
#(
  parameter int unsigned MAZE_W = 16,
  parameter int unsigned MAZE_H = 16,
  parameter int unsigned XW     = (MAZE_W > 1) ? $clog2(MAZE_W) : 1,
  parameter int unsigned YW     = (MAZE_H > 1) ? $clog2(MAZE_H) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [15:0]                            seed,
  input  logic [XW-1:0]                          start_x,
  input  logic [YW-1:0]                          start_y,
  output logic                                   busy,
  output logic                                   done,
  output logic [$clog2(MAZE_W*MAZE_H+1)-1:0]     cells_carved,
  input  logic [XW-1:0]                          rd_x,
  input  logic [YW-1:0]                          rd_y,
  output logic [2:0]                             rd_cell
);

  localparam int unsigned NCELL = MAZE_W * MAZE_H;
  localparam int unsigned PW    = $clog2(NCELL + 1);
  localparam int unsigned IW    = (NCELL > 1) ? $clog2(NCELL) : 1;

  state_e            state_q, state_d;
  logic [PW-1:0]     init_q, init_d;
  logic [PW-1:0]     sp_q, sp_d;
  logic [PW-1:0]     carved_q, carved_d;
  logic [XW-1:0]     cur_x_q, cur_x_d, st_x_q, st_x_d;
  logic [YW-1:0]     cur_y_q, cur_y_d, st_y_q, st_y_d;
  logic [2:0]        cells_q [NCELL];
  logic [2:0]        cells_d [NCELL];
  logic [2:0]        rd_q, rd_d;
  logic [XW+YW-1:0]  stack_q [NCELL];
  logic              push;
  logic [IW-1:0]     push_addr;
  logic [XW+YW-1:0]  push_data;
  logic              lfsr_load, lfsr_adv;
  logic [1:0]        rnd;
  logic [3:0]        mask;
  logic [1:0]        d;
  logic              found;
  dir_e              dir;
  int                cx, cy, nx, ny;

  function automatic logic [IW-1:0] idx(input int x, input int y);
    return IW'(y * int'(MAZE_W) + x);
  endfunction

  maze_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (seed),
    .adv   (lfsr_adv),
    .rnd   (rnd)
  );

  // FSM next-state, cell-store updates and stack push request.
  always_comb begin
    state_d   = state_q;
    init_d    = init_q;
    sp_d      = sp_q;
    carved_d  = carved_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    st_x_d    = st_x_q;
    st_y_d    = st_y_q;
    cells_d   = cells_q;
    push      = 1'b0;
    push_addr = '0;
    push_data = '0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    cx        = int'(cur_x_q);
    cy        = int'(cur_y_q);
    nx        = cx;
    ny        = cy;
    found     = 1'b0;
    dir       = DirUp;
    d         = 2'd0;

    // Bit n of mask corresponds to dir_e value n.
    mask = 4'b0000;
    if (cy > 0)                 mask[0] = !cells_q[idx(cx, cy - 1)][VISITED];
    if (cx > 0)                 mask[1] = !cells_q[idx(cx - 1, cy)][VISITED];
    if (cy < int'(MAZE_H) - 1)  mask[2] = !cells_q[idx(cx, cy + 1)][VISITED];
    if (cx < int'(MAZE_W) - 1)  mask[3] = !cells_q[idx(cx + 1, cy)][VISITED];

    // Scan r, r+1, r+2, r+3 (mod 4) and take the first open direction.
    for (int k = 0; k < 4; k++) begin
      d = 2'(int'(rnd) + k);
      if (!found && mask[d]) begin
        found = 1'b1;
        dir   = dir_e'(d);
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StInit;
          init_d    = '0;
          carved_d  = '0;
          st_x_d    = (int'(start_x) < int'(MAZE_W)) ? start_x : '0;
          st_y_d    = (int'(start_y) < int'(MAZE_H)) ? start_y : '0;
          lfsr_load = 1'b1;
        end
      end
      StInit: begin
        cells_d[IW'(init_q)] = CELL_INIT;
        if (init_q == PW'(NCELL - 1)) state_d = StSeed;
        else                          init_d  = init_q + PW'(1);
      end
      StSeed: begin
        cells_d[idx(int'(st_x_q), int'(st_y_q))][VISITED] = 1'b1;
        push      = 1'b1;
        push_addr = '0;
        push_data = {st_x_q, st_y_q};
        sp_d      = PW'(1);
        cur_x_d   = st_x_q;
        cur_y_d   = st_y_q;
        carved_d  = PW'(1);
        state_d   = StStep;
      end
      StStep: begin
        lfsr_adv = 1'b1;
        if (found) begin
          // Each wall is owned by the upper/left cell of the pair it separates.
          unique case (dir)
            DirUp: begin
              ny = cy - 1;
              cells_d[idx(cx, cy - 1)][WALL_DOWN] = 1'b0;
            end
            DirLeft: begin
              nx = cx - 1;
              cells_d[idx(cx - 1, cy)][WALL_RIGHT] = 1'b0;
            end
            DirDown: begin
              ny = cy + 1;
              cells_d[idx(cx, cy)][WALL_DOWN] = 1'b0;
            end
            DirRight: begin
              nx = cx + 1;
              cells_d[idx(cx, cy)][WALL_RIGHT] = 1'b0;
            end
            default: ;
          endcase
          cells_d[idx(nx, ny)][VISITED] = 1'b1;
          push      = 1'b1;
          push_addr = IW'(sp_q);
          push_data = {XW'(nx), YW'(ny)};
          sp_d      = sp_q + PW'(1);
          cur_x_d   = XW'(nx);
          cur_y_d   = YW'(ny);
          carved_d  = carved_q + PW'(1);
        end else begin
          sp_d = sp_q - PW'(1);
          if (sp_d == '0) state_d = StDone;
          else            {cur_x_d, cur_y_d} = stack_q[IW'(sp_q - PW'(2))];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read port: sample the pre-update store; out-of-grid addresses read as a fresh cell.
  always_comb begin
    rd_d = CELL_INIT;
    if (int'(rd_x) < int'(MAZE_W) && int'(rd_y) < int'(MAZE_H)) begin
      rd_d = cells_q[idx(int'(rd_x), int'(rd_y))];
    end
  end

  // Control state, cell store and read register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      init_q   <= '0;
      sp_q     <= '0;
      carved_q <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      st_x_q   <= '0;
      st_y_q   <= '0;
      rd_q     <= CELL_INIT;
      for (int i = 0; i < int'(NCELL); i++) cells_q[i] <= CELL_INIT;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      sp_q     <= sp_d;
      carved_q <= carved_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      st_x_q   <= st_x_d;
      st_y_q   <= st_y_d;
      rd_q     <= rd_d;
      cells_q  <= cells_d;
    end
  end

  // Coordinate stack; entries above the pointer are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push) stack_q[push_addr] <= push_data;
  end

  assign busy         = (state_q == StInit) || (state_q == StSeed) || (state_q == StStep);
  assign done         = (state_q == StDone);
  assign cells_carved = carved_q;
  assign rd_cell      = rd_q;

endmodule

// File: tb/tb_maze_carver_gen.sv
// Bench for maze_carver_gen: 1x1, 2x2 and 16x16 instances against a stack-based reference.
module tb_maze_carver_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  // 1x1 instance
  logic        a_start, a_busy, a_done;
  logic [15:0] a_seed;
  logic [0:0]  a_sx, a_sy, a_rx, a_ry, a_cnt;
  logic [2:0]  a_rd;
  // 2x2 instance
  logic        b_start, b_busy, b_done;
  logic [15:0] b_seed;
  logic [0:0]  b_sx, b_sy, b_rx, b_ry;
  logic [2:0]  b_cnt, b_rd;
  // 16x16 instance, 5-bit coordinates so out-of-range starts are expressible
  logic        c_start, c_busy, c_done;
  logic [15:0] c_seed;
  logic [4:0]  c_sx, c_sy, c_rx, c_ry;
  logic [8:0]  c_cnt;
  logic [2:0]  c_rd;

  maze_carver_gen #(.MAZE_W(1), .MAZE_H(1)) u_a (
    .clk(clk), .reset(reset_n), .start(a_start), .seed(a_seed), .start_x(a_sx),
    .start_y(a_sy), .busy(a_busy), .done(a_done), .cells_carved(a_cnt), .rd_x(a_rx),
    .rd_y(a_ry), .rd_cell(a_rd));

  maze_carver_gen #(.MAZE_W(2), .MAZE_H(2)) u_b (
    .clk(clk), .reset(reset_n), .start(b_start), .seed(b_seed), .start_x(b_sx),
    .start_y(b_sy), .busy(b_busy), .done(b_done), .cells_carved(b_cnt), .rd_x(b_rx),
    .rd_y(b_ry), .rd_cell(b_rd));

  maze_carver_gen #(.MAZE_W(16), .MAZE_H(16), .XW(5), .YW(5)) u_c (
    .clk(clk), .reset(reset_n), .start(c_start), .seed(c_seed), .start_x(c_sx),
    .start_y(c_sy), .busy(c_busy), .done(c_done), .cells_carved(c_cnt), .rd_x(c_rx),
    .rd_y(c_ry), .rd_cell(c_rd));

  logic [2:0] exp_m [256];
  logic [2:0] got_m [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: backtracker over a coordinate queue; cur is always the stack top.
  task automatic model(input int w, input int h, input logic [15:0] sd, input int sx_in,
                       input int sy_in);
    logic [15:0] l;
    int qx[$], qy[$];
    int cx, cy, nx, ny, r, dd, sx, sy;
    bit found;
    l  = (sd == 16'h0) ? 16'hACE1 : sd;
    sx = (sx_in >= w) ? 0 : sx_in;
    sy = (sy_in >= h) ? 0 : sy_in;
    for (int i = 0; i < w * h; i++) exp_m[i] = 3'b011;
    exp_m[sy * w + sx][2] = 1'b1;
    qx.push_back(sx);
    qy.push_back(sy);
    while (qx.size() > 0) begin
      cx = qx[$];
      cy = qy[$];
      r  = int'(l[1:0]);
      found = 1'b0;
      nx = cx;
      ny = cy;
      for (int k = 0; k < 4 && !found; k++) begin
        dd = (r + k) % 4;
        nx = cx;
        ny = cy;
        case (dd)
          0: ny = cy - 1;
          1: nx = cx - 1;
          2: ny = cy + 1;
          default: nx = cx + 1;
        endcase
        if (nx >= 0 && nx < w && ny >= 0 && ny < h && !exp_m[ny * w + nx][2]) found = 1'b1;
      end
      if (found) begin
        if (ny != cy) exp_m[((ny < cy) ? ny : cy) * w + cx][1] = 1'b0;
        else          exp_m[cy * w + ((nx < cx) ? nx : cx)][0] = 1'b0;
        exp_m[ny * w + nx][2] = 1'b1;
        qx.push_back(nx);
        qy.push_back(ny);
      end else begin
        void'(qx.pop_back());
        void'(qy.pop_back());
      end
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
  endtask

  task automatic cmp_maze(input string tag, input int nc);
    int mism = 0;
    for (int i = 0; i < nc; i++) if (got_m[i] !== exp_m[i]) mism++;
    check(tag, mism, 0);
  endtask

  // Structural properties of got_m: cleared internal walls, boundary, visits, BFS reach.
  task automatic check_props(input string tag, input int w, input int h);
    bit seen [256];
    int q[$];
    int c, x, y, cleared, bnd, unvis, reach;
    cleared = 0; bnd = 0; unvis = 0; reach = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < w * h; i++) begin
      x = i % w;
      y = i / w;
      if (!got_m[i][2]) unvis++;
      if (!got_m[i][0]) begin if (x == w - 1) bnd++; else cleared++; end
      if (!got_m[i][1]) begin if (y == h - 1) bnd++; else cleared++; end
    end
    q.push_back(0);
    seen[0] = 1'b1;
    while (q.size() > 0) begin
      c = q.pop_front();
      reach++;
      x = c % w;
      y = c / w;
      if (x < w - 1 && !got_m[c][0] && !seen[c + 1]) begin seen[c + 1] = 1; q.push_back(c + 1); end
      if (x > 0 && !got_m[c - 1][0] && !seen[c - 1]) begin seen[c - 1] = 1; q.push_back(c - 1); end
      if (y < h - 1 && !got_m[c][1] && !seen[c + w]) begin seen[c + w] = 1; q.push_back(c + w); end
      if (y > 0 && !got_m[c - w][1] && !seen[c - w]) begin seen[c - w] = 1; q.push_back(c - w); end
    end
    check({tag, "_cleared"}, cleared, w * h - 1);
    check({tag, "_boundary"}, bnd, 0);
    check({tag, "_unvisited"}, unvis, 0);
    check({tag, "_bfs_reach"}, reach, w * h);
  endtask

  function automatic logic [767:0] pack_got();
    logic [767:0] p;
    for (int i = 0; i < 256; i++) p[i*3 +: 3] = got_m[i];
    return p;
  endfunction

  task automatic read16();
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        c_rx = 5'(x);
        c_ry = 5'(y);
        @(posedge clk); #1;
        got_m[y * 16 + x] = c_rd;
      end
    end
  endtask

  // All tasks below begin and end 1 time unit after a rising edge.
  task automatic run16(input string tag, input logic [15:0] sd, input int sx, input int sy);
    int n;
    model(16, 16, sd, sx, sy);
    c_seed  = sd;
    c_sx    = 5'(sx);
    c_sy    = 5'(sy);
    c_rx    = 5'((sx >= 16) ? 0 : sx);
    c_ry    = 5'((sy >= 16) ? 0 : sy);
    c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
    check({tag, "_busy_after_start"}, c_busy, 1);
    check({tag, "_done_cleared"}, c_done, 0);
    n = 0;
    while (n < 2000 && !c_done) begin
      @(posedge clk); #1;
      n++;
      if (n == 257) check({tag, "_start_pre_seed"}, c_rd, 3'b011);
      if (n == 258) check({tag, "_start_visited"}, c_rd[2], 1);
    end
    check({tag, "_done_edges"}, n, 768);
    check({tag, "_cells_carved"}, c_cnt, 256);
    read16();
    cmp_maze({tag, "_maze"}, 256);
    check_props(tag, 16, 16);
  endtask

  task automatic run2(input string tag, input logic [15:0] sd, input int sx, input int sy);
    int n;
    model(2, 2, sd, sx, sy);
    b_seed  = sd;
    b_sx    = 1'(sx);
    b_sy    = 1'(sy);
    b_rx    = 1'(sx);
    b_ry    = 1'(sy);
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    n = 0;
    while (n < 200 && !b_done) begin
      @(posedge clk); #1;
      n++;
      if (n == 6) check({tag, "_start_visited"}, b_rd[2], 1);
    end
    check({tag, "_done_edges"}, n, 12);
    check({tag, "_cells_carved"}, b_cnt, 4);
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 2; x++) begin
        b_rx = 1'(x);
        b_ry = 1'(y);
        @(posedge clk); #1;
        got_m[y * 2 + x] = b_rd;
      end
    end
    cmp_maze({tag, "_maze"}, 4);
    check_props(tag, 2, 2);
  endtask

  initial begin
    logic [767:0] p1, p2, p3, p4;
    int n, bad;
    logic [15:0] rs;

    reset_n = 1'b0;
    a_start = 0; a_seed = 0; a_sx = 0; a_sy = 0; a_rx = 0; a_ry = 0;
    b_start = 0; b_seed = 0; b_sx = 0; b_sy = 0; b_rx = 0; b_ry = 0;
    c_start = 0; c_seed = 0; c_sx = 0; c_sy = 0; c_rx = 0; c_ry = 0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", c_busy, 0);
    check("rst_done", c_done, 0);
    check("rst_cells_carved", c_cnt, 0);
    check("rst_rd_cell", c_rd, 3'b011);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1x1: start is the only cell, one pop finishes.
    a_seed  = 16'h0001;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    n = 0;
    while (n < 100 && !a_done) begin @(posedge clk); #1; n++; end
    check("w1_done_edges", n, 3);
    check("w1_busy_low", a_busy, 0);
    check("w1_cells_carved", a_cnt, 1);
    @(posedge clk); #1;
    check("w1_rd_cell", a_rd, 3'b111);

    // 2x2: fixed seed twice must repeat, plus random seeds/starts.
    run2("w2_a", 16'h1234, 0, 0);
    p1 = pack_got();
    run2("w2_b", 16'h1234, 0, 0);
    p2 = pack_got();
    check("w2_repeat_identical", (p1 === p2), 1);
    for (int i = 0; i < 3; i++) begin
      rs = 16'($urandom);
      run2("w2_rand", rs, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    // 16x16 with distinct seeds.
    run16("s1", 16'h0001, 0, 0);
    p1 = pack_got();
    run16("s2", 16'h0002, 0, 0);
    p2 = pack_got();
    run16("sbeef", 16'hBEEF, 0, 0);
    p3 = pack_got();
    check("seeds_1_2_differ", (p1 !== p2), 1);
    check("seeds_1_beef_differ", (p1 !== p3), 1);
    check("seeds_2_beef_differ", (p2 !== p3), 1);

    // Corner start, and an out-of-range x that falls back to column 0.
    run16("corner", 16'($urandom), 15, 15);
    run16("x20", 16'($urandom), 20, int'($urandom_range(0, 15)));

    // Reset pulse mid-generation.
    c_seed  = 16'($urandom);
    c_sx    = 0;
    c_sy    = 0;
    c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
    repeat (99) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", c_busy, 0);
    check("midrst_done", c_done, 0);
    check("midrst_cells_carved", c_cnt, 0);
    check("midrst_rd_cell", c_rd, 3'b011);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    read16();
    bad = 0;
    for (int i = 0; i < 256; i++) if (got_m[i] !== 3'b011) bad++;
    check("midrst_store_cleared", bad, 0);
    run16("after_rst", 16'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

    // start held high: ignored while busy, re-accepted from DONE; seed 0 acts as ACE1.
    c_seed  = 16'hACE1;
    c_sx    = 0;
    c_sy    = 0;
    c_start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (n < 2000 && !c_done) begin @(posedge clk); #1; n++; end
    check("hold_done_edges", n, 768);
    c_seed = 16'h0000;
    @(posedge clk); #1;
    check("hold_restart_done_low", c_done, 0);
    check("hold_restart_busy", c_busy, 1);
    n = 0;
    while (n < 2000 && !c_done) begin @(posedge clk); #1; n++; end
    check("hold_done_edges2", n, 768);
    c_start = 1'b0;
    read16();
    p4 = pack_got();
    model(16, 16, 16'hACE1, 0, 0);
    cmp_maze("seed0_equals_ace1", 256);
    run16("ace1", 16'hACE1, 0, 0);
    check("seed0_vs_ace1_run", (pack_got() === p4), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
